// File: rtl/div8_serial.sv
// ---------------------------------------------------------------------------
// div8_serial
//   Iterative restoring fixed-point divider: q = floor((a << W) / b) and
//   r = (a << W) mod b. It undoes the parallel multiplier p = (a*b) >> W.
//   One quotient bit is produced per clock, so a normal division takes W+1
//   edges from the accepted start to the valid_o pulse. Divide-by-zero and
//   a >= b saturate to all-ones and report after a single extra edge.
//
// Handshake: start_i is accepted only in IDLE while valid_o is low. The
//   accepted edge captures a_i/b_i. busy_o is high for the W iteration
//   cycles. valid_o pulses for one cycle; q_o, r_o, ovf_o and dz_o hold
//   until the next result. Starts that arrive while busy_o or valid_o is
//   high are dropped.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  request pulse
//   a_i      dividend (before the << W scaling)
//   b_i      divisor
//   busy_o   division in progress
//   valid_o  one-cycle result strobe
//   q_o      quotient
//   r_o      remainder
//   ovf_o    saturation flag (a >= b, b != 0)
//   dz_o     divide-by-zero flag
// ---------------------------------------------------------------------------
module div8_serial #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         busy_o,
   output logic         valid_o,
   output logic [W-1:0] q_o,
   output logic [W-1:0] r_o,
   output logic         ovf_o,
   output logic         dz_o
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sat_q, sat_d;      // pending saturation flag
   logic           zer_q, zer_d;      // pending divide-by-zero flag
   logic           valid_q, valid_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   r_q, r_d;
   logic           ovf_q, ovf_d;
   logic           dz_q, dz_d;

   logic [W:0]     rem_sh;
   logic [W:0]     diff;
   logic           ge;

   // The remainder is always below b, so the shifted value is below 2b and
   // fits in W+1 bits. When rem_sh >= b the difference is below b (< 2^W),
   // so its MSB is 0; otherwise the W+1 bit result wraps to at least
   // 2^(W+1) - b > 2^W and its MSB is 1. The MSB is therefore the borrow.
   assign rem_sh = {rem_q, 1'b0};
   assign diff   = rem_sh - {1'b0, b_q};
   assign ge     = ~diff[W];

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      zer_d   = zer_q;
      valid_d = 1'b0;
      q_d     = q_q;
      r_d     = r_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;

      unique case (state_q)
         IDLE: begin
            // The valid_o cycle is spent in IDLE; a start there is dropped.
            if (start_i && !valid_q) begin
               b_d   = b_i;
               cnt_d = '0;
               if (b_i == '0) begin
                  quo_d   = '1;
                  rem_d   = '0;
                  zer_d   = 1'b1;
                  sat_d   = 1'b0;
                  state_d = DONE;
               end else if (a_i >= b_i) begin
                  quo_d   = '1;
                  rem_d   = '0;
                  zer_d   = 1'b0;
                  sat_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = '0;
                  rem_d   = a_i;
                  zer_d   = 1'b0;
                  sat_d   = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = ge ? diff[W-1:0] : rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            valid_d = 1'b1;
            q_d     = quo_q;
            r_d     = rem_q;
            ovf_d   = sat_q;
            dz_d    = zer_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         zer_q   <= 1'b0;
         valid_q <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         zer_q   <= zer_d;
         valid_q <= valid_d;
         q_q     <= q_d;
         r_q     <= r_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   assign busy_o  = (state_q == CALC);
   assign valid_o = valid_q;
   assign q_o     = q_q;
   assign r_o     = r_q;
   assign ovf_o   = ovf_q;
   assign dz_o    = dz_q;

endmodule

// File: tb/tb_div8_serial.sv
module tb_div8_serial;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         busy_o;
   logic         valid_o;
   logic [W-1:0] q_o;
   logic [W-1:0] r_o;
   logic         ovf_o;
   logic         dz_o;

   int n_checks = 0;
   int n_pass   = 0;

   div8_serial #(.W(W)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .q_o     (q_o),
      .r_o     (r_o),
      .ovf_o   (ovf_o),
      .dz_o    (dz_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic ovf, output logic dz, output int lat,
                        output int busy_cycles);
      int num;
      num = int'(a) * (1 << W);
      if (b == 0) begin
         q = '1; r = '0; ovf = 1'b0; dz = 1'b1;
         lat = 2; busy_cycles = 0;
      end else if (a >= b) begin
         q = '1; r = '0; ovf = 1'b1; dz = 1'b0;
         lat = 2; busy_cycles = 0;
      end else begin
         q = W'(num / int'(b));
         r = W'(num % int'(b));
         ovf = 1'b0; dz = 1'b0;
         lat = W + 2; busy_cycles = W;
      end
   endtask

   // ---------------- driver ----------------
   // Issues one start on the next falling edge, then samples once per cycle
   // (on falling edges) until valid_o. lat counts falling edges after the
   // start edge. Operand inputs are scrambled after acceptance, and an
   // optional extra start is injected at cycle inject_at.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input string tag);
      logic [W-1:0] eq, er;
      logic         eovf, edz;
      int           elat, ebusy;
      int           lat, busy_n;
      bit           got;
      model(a, b, eq, er, eovf, edz, elat, ebusy);
      @(negedge clk);
      start_i = 1'b1; a_i = a; b_i = b;
      lat = 0; busy_n = 0; got = 0;
      while (!got && lat < 30) begin
         @(negedge clk);
         lat++;
         if (busy_o) busy_n++;
         if (valid_o) got = 1;
         start_i = 1'b0;
         a_i = W'($urandom);
         b_i = W'($urandom);
         if (!got && lat == inject_at) begin
            start_i = 1'b1; a_i = 8'h01; b_i = 8'h02;
         end
      end
      start_i = 1'b0;
      check_eq({tag, "_valid"}, 32'(got), 32'd1);
      if (got) begin
         check_eq({tag, "_lat"},  32'(lat),    32'(elat));
         check_eq({tag, "_busy"}, 32'(busy_n), 32'(ebusy));
         check_eq({tag, "_q"},    32'(q_o),    32'(eq));
         check_eq({tag, "_r"},    32'(r_o),    32'(er));
         check_eq({tag, "_ovf"},  32'(ovf_o),  32'(eovf));
         check_eq({tag, "_dz"},   32'(dz_o),   32'(edz));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int vcount;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_busy",  32'(busy_o),  32'd0);
      check_eq("rst_valid", 32'(valid_o), 32'd0);
      check_eq("rst_q",     32'(q_o),     32'd0);
      check_eq("rst_r",     32'(r_o),     32'd0);
      check_eq("rst_ovf",   32'(ovf_o),   32'd0);
      check_eq("rst_dz",    32'(dz_o),    32'd0);
      vcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (valid_o) vcount++;
      end
      check_eq("idle_no_valid", 32'(vcount), 32'd0);

      // Directed cases with hand-derived results.
      run_div(8'h45, 8'h55, 0, "d45_55");
      check_eq("d45_55_qk", 32'(q_o), 32'hCF);
      check_eq("d45_55_rk", 32'(r_o), 32'h45);
      run_div(8'h16, 8'h55, 0, "rt");
      check_eq("rt_qk", 32'(q_o), 32'h42);
      check_eq("rt_rk", 32'(r_o), 32'h16);
      run_div(8'h00, 8'h07, 0, "b2b");
      run_div(8'h80, 8'h80, 0, "ovf");
      check_eq("ovf_qk", 32'(q_o), 32'hFF);
      run_div(8'h12, 8'h00, 0, "dz");
      check_eq("dz_flagk", 32'(dz_o), 32'd1);

      // Extra start mid-operation is dropped.
      run_div(8'h45, 8'h55, 3, "inj");
      check_eq("inj_qk", 32'(q_o), 32'hCF);
      check_eq("inj_rk", 32'(r_o), 32'h45);

      // Start during the valid_o cycle is dropped; results hold.
      start_i = 1'b1; a_i = 8'h12; b_i = 8'h00;
      @(negedge clk);
      start_i = 1'b0;
      check_eq("pulse_width", 32'(valid_o), 32'd0);
      vcount = 0;
      repeat (4) begin
         if (valid_o) vcount++;
         @(negedge clk);
      end
      check_eq("vstart_ignored", 32'(vcount), 32'd0);
      check_eq("hold_q",  32'(q_o),  32'hCF);
      check_eq("hold_dz", 32'(dz_o), 32'd0);

      // Reset during a division aborts it.
      start_i = 1'b1; a_i = 8'h45; b_i = 8'h55;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(busy_o), 32'd0);
      check_eq("abort_q",    32'(q_o),    32'd0);
      check_eq("abort_r",    32'(r_o),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vcount = 0;
      repeat (12) begin
         @(negedge clk);
         if (valid_o) vcount++;
      end
      check_eq("abort_no_valid", 32'(vcount), 32'd0);
      run_div(8'h01, 8'h02, 0, "post_rst");
      check_eq("post_rst_qk", 32'(q_o), 32'h80);

      // Randomized operands against the model.
      for (int i = 0; i < 30; i++) begin
         if (i % 6 == 5) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
         end else begin
            rb = W'($urandom_range(1, 255));
            ra = W'($urandom_range(0, int'(rb) - 1));
         end
         run_div(ra, rb, 0, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/div8_serial.md
Name: div8_serial

Overview:
- Iterative fixed-point divider. It is the inverse of the team's 8-bit parallel multiplier, whose result is p = (a*b)>>8.
- Computes q = floor((a_i<<W)/b_i), so a multiplier product p and operand b give back the other operand, truncated.
- Implemented as a restoring shift-subtract unit that produces one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and talks to it through a start/busy/valid handshake.

Parameters:
- W, 8, operand, quotient and remainder width in bits. Normal-case latency is W+1 cycles.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request pulse; sampled only while busy_o=0.
- a_i  input  W  dividend (numerator before the <<W scaling); captured on an accepted start.
- b_i  input  W  divisor; captured on an accepted start.
- busy_o  output  1  high while a division is in progress.
- valid_o  output  1  one-cycle pulse; q_o, r_o and the flags are valid in this cycle.
- q_o  output  W  quotient.
- r_o  output  W  remainder, equal to (a<<W) mod b.
- ovf_o  output  1  saturation flag (a >= b, b != 0).
- dz_o  output  1  divide-by-zero flag.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; busy_o=0, valid_o=0, q_o=0, r_o=0, ovf_o=0, dz_o=0. Internal remainder, quotient and counter registers are cleared.
- Reset mid-operation aborts the division immediately. No valid_o follows. After release the block is in IDLE and accepts a new start.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start_i=1 at edge k, latch a_i and b_i.
  - If b_i=0: go to DONE with q=all-ones, r=0, dz=1, ovf=0.
  - Else if a_i >= b_i: go to DONE with q=all-ones, r=0, ovf=1, dz=0.
  - Otherwise: go to CALC with rem=a_i (W+1 bits wide), quotient=0, cnt=0, busy_o=1 from k+1.
- CALC, each edge:
  - rem = rem<<1.
  - If rem >= b: rem = rem-b and shift a 1 into the quotient LSB; otherwise shift in 0.
  - cnt increments.
  - After the W-th iteration (edge k+W), go to DONE.
- DONE, one cycle:
  - Register q_o, r_o (= rem[W-1:0]), ovf_o and dz_o.
  - Pulse valid_o=1 for exactly one cycle; busy_o=0 in that cycle.
  - Return to IDLE.
- Latency:
  - Normal case: valid_o is high in the cycle after edge k+W+1, i.e. W+1 edges after the start edge.
  - Special cases (dz/ovf): valid_o is high after edge k+1. busy_o is never asserted.
- start_i while busy_o=1 or valid_o=1 is ignored. No queueing, no error.
- start_i in the cycle immediately after valid_o (FSM back in IDLE) is accepted, giving back-to-back operation.
- q_o, r_o, ovf_o and dz_o hold their values until the next DONE. valid_o is the only pulsed output.
- a_i and b_i may change freely after the accepted start edge without affecting the result.
- Arithmetic:
  - The comparison and subtraction use W+1 bits so that the shifted remainder cannot overflow.
  - For a < b the quotient always fits in W bits.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> all outputs 0, busy_o=0; start_i held 0 -> valid_o never asserts.
- a=0x45, b=0x55, start -> busy_o high for 8 cycles, valid_o at start+9: q_o=0xCF, r_o=0x45, ovf_o=0, dz_o=0.
- Round trip on the multiplier product (p=0x16 from 0x45*0x55>>8): a=0x16, b=0x55 -> q_o=0x42, r_o=0x16. Back-to-back start in the cycle after valid_o with a=0x00, b=0x07 -> q_o=0x00, r_o=0x00.
- a=0x80, b=0x80 -> valid_o at start+1: q_o=0xFF, r_o=0, ovf_o=1. Then a=0x12, b=0x00 -> q_o=0xFF, dz_o=1, ovf_o=0. busy_o stays 0 throughout both.
- Start a=0x45, b=0x55; pulse start_i again with a=0x01, b=0x02 at start+3 -> ignored, result still q_o=0xCF, r_o=0x45.
- Start a division, drop rst_n at start+4 for 1 cycle -> outputs cleared asynchronously, no valid_o. A new start with a=0x01, b=0x02 -> q_o=0x80, r_o=0x00.
